// File: rtl/cacheline_adapter.sv
// ============================================================================
// cacheline_adapter - converts full-line DFP requests into fixed-length bursts
// Rev 1.0
// ============================================================================
`default_nettype none

module cacheline_adapter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BITS  = 256,
    parameter int BEAT_BITS  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] dfp_addr,
    input  logic                  dfp_read,
    input  logic                  dfp_write,
    input  logic [LINE_BITS-1:0]  dfp_wdata,
    output logic [LINE_BITS-1:0]  dfp_rdata,
    output logic                  dfp_resp,
    output logic [ADDR_WIDTH-1:0] bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [BEAT_BITS-1:0]  bmem_wdata,
    input  logic                  bmem_ready,
    input  logic [BEAT_BITS-1:0]  bmem_rdata,
    input  logic                  bmem_rvalid
);

    localparam int BEATS    = LINE_BITS / BEAT_BITS;
    localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_BITS = $clog2(LINE_BITS / 8);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'((1 << OFF_BITS) - 1);
    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RD_REQ     = 3'd1,
        S_RD_COLLECT = 3'd2,
        S_WR_BURST   = 3'd3,
        S_RESP       = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [LINE_BITS-1:0]   wline_q, wline_d;
    logic [LINE_BITS-1:0]   rline_q, rline_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rline_d = rline_q;
        case (state_q)
            S_IDLE: begin
                // Read has priority when both requests are raised together.
                if (dfp_read) begin
                    addr_d  = dfp_addr & ADDR_MASK;
                    cnt_d   = '0;
                    state_d = S_RD_REQ;
                end else if (dfp_write) begin
                    addr_d  = dfp_addr & ADDR_MASK;
                    wline_d = dfp_wdata;
                    cnt_d   = '0;
                    state_d = S_WR_BURST;
                end
            end
            S_RD_REQ: begin
                if (bmem_ready) state_d = S_RD_COLLECT;
            end
            S_RD_COLLECT: begin
                if (bmem_rvalid) begin
                    rline_d[int'(cnt_q)*BEAT_BITS +: BEAT_BITS] = bmem_rdata;
                    if (cnt_q == LAST_BEAT) state_d = S_RESP;
                    else                    cnt_d   = cnt_q + 1'b1;
                end
            end
            S_WR_BURST: begin
                if (bmem_ready) begin
                    if (cnt_q == LAST_BEAT) state_d = S_RESP;
                    else                    cnt_d   = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
        end
    end

    assign dfp_rdata  = rline_q;
    assign dfp_resp   = (state_q == S_RESP);
    assign bmem_addr  = addr_q;
    assign bmem_read  = (state_q == S_RD_REQ);
    assign bmem_write = (state_q == S_WR_BURST);
    assign bmem_wdata = wline_q[int'(cnt_q)*BEAT_BITS +: BEAT_BITS];

endmodule

`default_nettype wire

// File: tb/tb_cacheline_adapter.sv
// ============================================================================
// tb_cacheline_adapter - scoreboard bench for cacheline_adapter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cacheline_adapter;

    logic         clk;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    cacheline_adapter #(
        .ADDR_WIDTH(32),
        .LINE_BITS (256),
        .BEAT_BITS (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dfp_addr   (dfp_addr),
        .dfp_read   (dfp_read),
        .dfp_write  (dfp_write),
        .dfp_wdata  (dfp_wdata),
        .dfp_rdata  (dfp_rdata),
        .dfp_resp   (dfp_resp),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_wdata (bmem_wdata),
        .bmem_ready (bmem_ready),
        .bmem_rdata (bmem_rdata),
        .bmem_rvalid(bmem_rvalid)
    );

    typedef struct {
        logic [255:0] line;
        int           cyc;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
    } beat_t;

    resp_t       exp_resp_q[$];
    beat_t       exp_beat_q[$];
    logic [31:0] exp_rdreq_q[$];

    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    logic [255:0] last_rline = '0;
    resp_t        m_resp;
    beat_t        m_beat;
    logic [31:0]  m_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: samples on the falling edge, pops on every DUT event.
    always @(negedge clk) begin
        if (rst) begin
            if (dfp_read && dfp_write) begin
                checks++;
                failures++;
                $display("FAIL both_req cycle=%0d actual=read+write required=one", cyc);
            end
            if (dfp_resp) begin
                if (exp_resp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexp_resp cycle=%0d actual=1 required=0", cyc);
                end else begin
                    m_resp = exp_resp_q.pop_front();
                    check("resp_cycle", 256'(cyc), 256'(m_resp.cyc));
                    check("resp_rdata", dfp_rdata, m_resp.line);
                end
            end
            if (bmem_read && bmem_ready) begin
                if (exp_rdreq_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexp_rdreq cycle=%0d actual=%h required=none", cyc, bmem_addr);
                end else begin
                    m_addr = exp_rdreq_q.pop_front();
                    check("rdreq_addr", bmem_addr, m_addr);
                end
            end
            if (bmem_write && bmem_ready) begin
                if (exp_beat_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexp_beat cycle=%0d actual=%h required=none", cyc, bmem_wdata);
                end else begin
                    m_beat = exp_beat_q.pop_front();
                    check("wr_addr", bmem_addr, m_beat.addr);
                    check("wr_beat", bmem_wdata, m_beat.data);
                end
            end
        end
    end

    task automatic do_read(input logic [31:0] addr, input logic [63:0] b0, input logic [63:0] b1,
                           input logic [63:0] b2, input logic [63:0] b3, input int rdly, input int gap);
        logic [63:0]  beats [4];
        logic [255:0] line;
        resp_t        e;
        int           r;
        int           l;
        beats = '{b0, b1, b2, b3};
        line  = {b3, b2, b1, b0};
        r = cyc + 1 + rdly;
        l = r + 1 + 3 * (gap + 1);
        exp_rdreq_q.push_back(addr & 32'hFFFF_FFE0);
        e.line = line;
        e.cyc  = l + 1;
        exp_resp_q.push_back(e);
        last_rline = line;
        dfp_addr = addr;
        dfp_read = 1'b1;
        tick();
        repeat (rdly) begin
            check("rd_hold", {bmem_read, bmem_addr}, {1'b1, addr & 32'hFFFF_FFE0});
            tick();
        end
        bmem_ready = 1'b1;
        tick();
        bmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) repeat (gap) tick();
            bmem_rvalid = 1'b1;
            bmem_rdata  = beats[i];
            tick();
            bmem_rvalid = 1'b0;
            bmem_rdata  = '0;
        end
        // Request still high during the response cycle; drop it one cycle later.
        tick();
        dfp_read = 1'b0;
        check("no_reaccept_rd", 256'({bmem_read, bmem_write}), 256'(0));
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                            input int stall_beat, input int stall_cycles);
        resp_t e;
        beat_t b;
        for (int i = 0; i < 4; i++) begin
            b.addr = addr & 32'hFFFF_FFE0;
            b.data = line[i*64 +: 64];
            exp_beat_q.push_back(b);
        end
        e.line = last_rline;
        e.cyc  = cyc + 4 + ((stall_beat >= 0) ? stall_cycles : 0) + 1;
        exp_resp_q.push_back(e);
        dfp_addr   = addr;
        dfp_wdata  = line;
        dfp_write  = 1'b1;
        bmem_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == stall_beat) begin
                bmem_ready = 1'b0;
                repeat (stall_cycles) begin
                    check("wr_hold", {bmem_write, bmem_wdata}, {1'b1, line[i*64 +: 64]});
                    tick();
                end
                bmem_ready = 1'b1;
            end
            tick();
        end
        tick();
        dfp_write  = 1'b0;
        bmem_ready = 1'b0;
        check("no_reaccept_wr", 256'({bmem_read, bmem_write}), 256'(0));
    endtask

    initial begin
        rst         = 1'b0;
        dfp_addr    = '0;
        dfp_read    = 1'b0;
        dfp_write   = 1'b0;
        dfp_wdata   = '0;
        bmem_ready  = 1'b0;
        bmem_rdata  = '0;
        bmem_rvalid = 1'b0;
        repeat (2) tick();
        check("rst_resp",  256'(dfp_resp), 256'(0));
        check("rst_read",  256'(bmem_read), 256'(0));
        check("rst_write", 256'(bmem_write), 256'(0));
        check("rst_addr",  256'(bmem_addr), 256'(0));
        check("rst_wdata", 256'(bmem_wdata), 256'(0));
        check("rst_rdata", dfp_rdata, 256'(0));
        rst = 1'b1;
        tick();

        // Single read, immediate ready, back-to-back beats
        do_read(32'h0000_1234, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}}, 0, 0);
        check("single_rd_line", dfp_rdata, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});
        repeat (2) tick();

        // Gapped read: ready after 3 cycles, 2-cycle gaps between beats
        do_read(32'h0000_40FF, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                64'hA5A5_5A5A_0F0F_F0F0, 64'h8000_0000_0000_0001, 3, 2);
        repeat (2) tick();

        // Single write with ready always high
        do_write(32'h0000_2008, {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, -1, 0);
        repeat (2) tick();

        // Write with ready low for 2 cycles on beat 1
        do_write(32'h0000_5FFF, {64'h4444_0000_0000_0004, 64'h3333_0000_0000_0003,
                                 64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001}, 1, 2);
        repeat (2) tick();

        // Read immediately followed by a write
        do_read(32'h0000_7760, 64'hCAFE_0000_0000_0000, 64'h0000_CAFE_0000_0000,
                64'h0000_0000_CAFE_0000, 64'h0000_0000_0000_CAFE, 0, 0);
        do_write(32'h0000_8000, {64'h9999_9999_9999_9999, 64'h8888_8888_8888_8888,
                                 64'h7777_7777_7777_7777, 64'h6666_6666_6666_6666}, -1, 0);
        check("rdata_kept", dfp_rdata, {64'h0000_0000_0000_CAFE, 64'h0000_0000_CAFE_0000,
                                        64'h0000_CAFE_0000_0000, 64'hCAFE_0000_0000_0000});
        repeat (2) tick();

        // Reset in the middle of a read after 2 beats
        exp_rdreq_q.push_back(32'h0000_3040);
        dfp_addr   = 32'h0000_3040;
        dfp_read   = 1'b1;
        bmem_ready = 1'b1;
        tick();
        tick();
        bmem_ready  = 1'b0;
        bmem_rvalid = 1'b1;
        bmem_rdata  = 64'hDEAD_BEEF_0000_0001;
        tick();
        bmem_rdata  = 64'hDEAD_BEEF_0000_0002;
        tick();
        rst      = 1'b0;
        dfp_read = 1'b0;
        bmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        #1;
        check("mid_rst_resp",  256'(dfp_resp), 256'(0));
        check("mid_rst_read",  256'(bmem_read), 256'(0));
        check("mid_rst_write", 256'(bmem_write), 256'(0));
        check("mid_rst_addr",  256'(bmem_addr), 256'(0));
        check("mid_rst_wdata", 256'(bmem_wdata), 256'(0));
        check("mid_rst_rdata", dfp_rdata, 256'(0));
        last_rline = '0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) begin
            tick();
            check("post_rst_idle", 256'({dfp_resp, bmem_read, bmem_write}), 256'(0));
            check("post_rst_rdata", dfp_rdata, 256'(0));
        end
        bmem_rvalid = 1'b0;
        bmem_rdata  = '0;
        tick();
        do_read(32'h0000_3040, 64'h1000_0000_0000_0001, 64'h2000_0000_0000_0002,
                64'h3000_0000_0000_0003, 64'h4000_0000_0000_0004, 1, 0);
        check("post_rst_line", dfp_rdata, {64'h4000_0000_0000_0004, 64'h3000_0000_0000_0003,
                                           64'h2000_0000_0000_0002, 64'h1000_0000_0000_0001});
        repeat (4) tick();

        check("resp_q_empty",  256'(exp_resp_q.size()), 256'(0));
        check("beat_q_empty",  256'(exp_beat_q.size()), 256'(0));
        check("rdreq_q_empty", 256'(exp_rdreq_q.size()), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends with a summary line.
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout cycle=%0d actual=running required=finished", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
